// File: rtl/booth_mul_ctrl.sv
// Issue/retire controller for an external Booth/Wallace multiplier with a 4-entry result FIFO.
// Define BOOTH_MUL_CTRL_STATS_EN to add the saturating op_cnt pop counter output.
module booth_mul_ctrl #(
  parameter int LAT = 3,
  parameter int W   = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic           flush,
  output logic [W-1:0]   dp_a,
  output logic [W-1:0]   dp_b,
  output logic           dp_issue,
  input  logic [2*W-1:0] dp_result,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p,
  output logic           busy
`ifdef BOOTH_MUL_CTRL_STATS_EN
  ,
  output logic [15:0]    op_cnt
`endif
);

  // state | meaning
  // IDLE  | held in / just out of reset, nothing accepted
  // RUN   | accepting operands and retiring results
  // FLUSH | one cycle after a flush; pipeline and FIFO already emptied
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic           issue_q, issue_d;
  logic [LAT-1:0] sr_q, sr_d;
  logic [2*W-1:0] mem_q [4];
  logic [1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [2:0]     cnt_q, cnt_d;

  logic [2:0] inflight;
  logic [3:0] occ;
  logic       pop, push, accept, flush_go;

  // The issue pulse counts as in flight: its result has not reached the shift register yet.
  always_comb begin
    inflight = {2'b00, issue_q};
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + {2'b00, sr_q[i]};
    end
  end

  assign out_valid = (cnt_q != 3'd0);
  assign pop       = out_valid && out_ready;
  assign push      = sr_q[LAT-1];
  assign occ       = {1'b0, inflight} + {1'b0, cnt_q};
  assign in_ready  = (state_q == ST_RUN) && (occ < (4'd4 + {3'b000, pop}));
  assign accept    = in_valid && in_ready;
  assign flush_go  = (state_q == ST_RUN) && flush;

  assign dp_a     = a_q;
  assign dp_b     = b_q;
  assign dp_issue = issue_q;
  assign out_p    = out_valid ? mem_q[rd_q] : '0;
  assign busy     = (inflight != 3'd0) || (cnt_q != 3'd0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_RUN;
      ST_RUN:   state_d = flush ? ST_FLUSH : ST_RUN;
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    a_d     = accept ? in_a : a_q;
    b_d     = accept ? in_b : b_q;
    issue_d = accept && !flush_go;
    sr_d    = '0;
    sr_d[0] = issue_q;
    for (int i = 1; i < LAT; i++) begin
      sr_d[i] = sr_q[i-1];
    end
    wr_d  = wr_q + {1'b0, push};
    rd_d  = rd_q + {1'b0, pop};
    cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};
    if (flush_go) begin
      sr_d  = '0;
      wr_d  = 2'd0;
      rd_d  = 2'd0;
      cnt_d = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      issue_q <= 1'b0;
      sr_q    <= '0;
      wr_q    <= 2'd0;
      rd_q    <= 2'd0;
      cnt_q   <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      issue_q <= issue_d;
      sr_q    <= sr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      if (push && !flush_go) begin
        mem_q[wr_q] <= dp_result;
      end
    end
  end

`ifdef BOOTH_MUL_CTRL_STATS_EN
  logic [15:0] op_cnt_q;

  // Survives flush on purpose: it is a lifetime count of delivered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt_q <= 16'd0;
    end else if (pop && (op_cnt_q != 16'hFFFF)) begin
      op_cnt_q <= op_cnt_q + 16'd1;
    end
  end

  assign op_cnt = op_cnt_q;
`endif

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Bench for booth_mul_ctrl: emulates the LAT-cycle datapath and checks every cycle against
// a queue-based model of accepted-but-not-delivered operations.
module tb_booth_mul_ctrl;
  localparam int LAT = 3;
  localparam int W   = 16;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a, in_b;
  logic           flush;
  logic [W-1:0]   dp_a, dp_b;
  logic           dp_issue;
  logic [2*W-1:0] dp_result;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;
  logic           busy;
`ifdef BOOTH_MUL_CTRL_STATS_EN
  logic [15:0]    op_cnt;
`endif

  booth_mul_ctrl #(.LAT(LAT), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .flush(flush), .dp_a(dp_a), .dp_b(dp_b),
    .dp_issue(dp_issue), .dp_result(dp_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_p(out_p), .busy(busy)
`ifdef BOOTH_MUL_CTRL_STATS_EN
    , .op_cnt(op_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic [2*W-1:0] p;
    int             rdy;
  } op_t;

  op_t            q[$];
  logic [2*W-1:0] pop_log[$];
  logic [2*W-1:0] pipe_p [0:LAT];
  logic           pipe_v [0:LAT];
  int             st = 0;          // 0 idle, 1 run, 2 flush
  logic           issue_exp = 1'b0;
  logic [W-1:0]   ea, eb;
  int             exp_cnt = 0;

  function automatic logic [2*W-1:0] mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Datapath emulation and per-cycle comparison against the model.
  always @(negedge clk) begin
    logic ov, pop_m, ir, acc;
    logic [2*W-1:0] pe;
    cyc++;
    for (int k = LAT; k > 0; k--) begin
      pipe_v[k] = pipe_v[k-1];
      pipe_p[k] = pipe_p[k-1];
    end
    pipe_v[0] = dp_issue;
    pipe_p[0] = mul(dp_a, dp_b);
    dp_result = pipe_v[LAT] ? pipe_p[LAT] : {$urandom, $urandom};

    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_dp_issue", dp_issue, 0);
      chk("rst_dp_a", dp_a, 0);
      chk("rst_dp_b", dp_b, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_p", out_p, 0);
      chk("rst_busy", busy, 0);
`ifdef BOOTH_MUL_CTRL_STATS_EN
      chk("rst_op_cnt", op_cnt, 0);
`endif
      q.delete();
      st        = 0;
      issue_exp = 1'b0;
      exp_cnt   = 0;
      for (int k = 0; k <= LAT; k++) pipe_v[k] = 1'b0;
    end else begin
      ov    = (q.size() > 0) && (q[0].rdy <= cyc);
      pe    = ov ? q[0].p : '0;
      pop_m = ov && out_ready;
      ir    = (st == 1) && (q.size() < 4 + (pop_m ? 1 : 0));
      chk("in_ready", in_ready, ir);
      chk("out_valid", out_valid, ov);
      chk("out_p", out_p, pe);
      chk("busy", busy, q.size() != 0);
      chk("dp_issue", dp_issue, issue_exp);
      if (issue_exp) begin
        chk("dp_a", dp_a, ea);
        chk("dp_b", dp_b, eb);
      end
`ifdef BOOTH_MUL_CTRL_STATS_EN
      chk("op_cnt", op_cnt, exp_cnt);
`endif
      if (out_valid && out_ready) pop_log.push_back(out_p);

      if (pop_m) begin
        void'(q.pop_front());
        if (exp_cnt < 16'hFFFF) exp_cnt++;
      end
      acc = in_valid && ir;
      if (st == 1 && flush) begin
        q.delete();
        issue_exp = 1'b0;
      end else if (acc) begin
        q.push_back('{mul(in_a, in_b), cyc + LAT + 2});
        issue_exp = 1'b1;
        ea = in_a;
        eb = in_b;
      end else begin
        issue_exp = 1'b0;
      end
      st = (st == 0) ? 1 : ((st == 1) ? (flush ? 2 : 1) : 1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_pops(input int n);
    int t = 0;
    while (pop_log.size() < n && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (pop_log.size() < n) chk("pop_timeout", pop_log.size(), n);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    flush = 1'b0; out_ready = 1'b0; dp_result = '0;
    #1 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // single op: 3 * -2
    out_ready = 1'b1;
    pop_log.delete();
    send(16'h0003, 16'hFFFE);
    repeat (LAT + 1) begin
      @(negedge clk);
      chk("single_early_valid", out_valid, 0);
    end
    @(negedge clk);
    chk("single_valid", out_valid, 1);
    chk("single_p", out_p, 32'hFFFFFFFA);
    step();

    // four back-to-back with consumer stalled, then pop while full
    out_ready = 1'b0;
    repeat (3) step();
    pop_log.delete();
    send(16'd1, 16'd1);
    send(16'd2, 16'd2);
    send(16'd3, 16'd3);
    send(16'd4, 16'd4);
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    repeat (LAT + 3) step();
    in_valid = 1'b1; in_a = 16'd6; in_b = 16'd7;
    @(negedge clk);
    chk("full_stall_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_pops(5);
    chk("order0", pop_log[0], 32'd1);
    chk("order1", pop_log[1], 32'd4);
    chk("order2", pop_log[2], 32'd9);
    chk("order3", pop_log[3], 32'd16);
    chk("order4", pop_log[4], 32'd42);
    repeat (5) step();

    // flush with one buffered and two in flight
    out_ready = 1'b0;
    send(16'd7, 16'd7);
    repeat (LAT + 2) step();
    send(16'd8, 16'd8);
    send(16'd9, 16'd9);
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_busy", busy, 0);
    out_ready = 1'b1;
    pop_log.delete();
    repeat (10) step();
    chk("flush_stale", pop_log.size(), 0);
    send(16'd5, 16'd5);
    wait_pops(1);
    chk("flush_next", pop_log[0], 32'd25);
    repeat (3) step();

    // reset while busy
    out_ready = 1'b0;
    send(16'd10, 16'd10);
    send(16'd11, 16'd11);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    pop_log.delete();
    send(16'hFFFF, 16'hFFFF);
    wait_pops(1);
    chk("rstmid_next", pop_log[0], 32'd1);
    repeat (8) step();
    chk("rstmid_stale", pop_log.size(), 1);

`ifdef BOOTH_MUL_CTRL_STATS_EN
    send(16'd2, 16'd3);
    send(16'd4, 16'd5);
    wait_pops(3);
    repeat (2) step();
    chk("stats_three", op_cnt, 16'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (2) step();
    chk("stats_after_flush", op_cnt, 16'd3);
`endif

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      in_a      = ($urandom_range(0, 7) == 0) ? 16'h8000 : W'($urandom);
      in_b      = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 99) < 2);
      rst_n     = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (20) step();
    chk("drain_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
